// File: rtl/fifo_read_operation.sv
// fifo_read_operation: read-side controller for the 8-entry register-file FIFO.
// Owns the read pointer, decodes a one-hot read select, registers read data and
// reports read acknowledge / underflow error through a three-state FSM.
// Optional feature macro: FIFO_RD_ERR_EN (enables the underflow error state and rd_err).
module fifo_read_operation #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rd_en,
    input  logic                    clr,
    input  logic [3:0]              count,
    input  logic [8*DATA_WIDTH-1:0] reg_data,
    output logic                    rd_take,
    output logic [7:0]              rd_sel,
    output logic [2:0]              rd_ptr,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    rd_ack,
    output logic                    rd_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StRdError
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    empty;

    // Illegal counts 9..15 are non-empty simply because they are non-zero.
    assign empty   = (count == 4'd0);
    assign rd_take = rd_en & ~empty & ~clr;

    // One-hot decode of the read pointer, only active on an accepted read.
    always_comb begin
        rd_sel = 8'b0;
        for (int i = 0; i < 8; i++) begin
            rd_sel[i] = rd_take && (rd_ptr_q == 3'(i));
        end
    end

    // Next-state logic: clr wins, then accepted read, then underflow.
    always_comb begin
        state_d = StIdle;
        if (clr) begin
            state_d = StIdle;
        end else if (rd_en && !empty) begin
            state_d = StRead;
        end else if (rd_en && empty) begin
`ifdef FIFO_RD_ERR_EN
            state_d = StRdError;
`else
            state_d = StIdle;
`endif
        end
    end

    // Pointer and data path: advance and capture only on an accepted read.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;
        if (clr) begin
            rd_ptr_d = 3'd0;
        end else if (rd_take) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
            dout_d   = reg_data[rd_ptr_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rd_ptr_q <= 3'd0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    assign rd_ptr = rd_ptr_q;
    assign dout   = dout_q;
    assign rd_ack = (state_q == StRead);
`ifdef FIFO_RD_ERR_EN
    assign rd_err = (state_q == StRdError);
`else
    assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_operation.sv
// Directed self-checking bench for fifo_read_operation.
module tb_fifo_read_operation;

    localparam int unsigned DW = 32;

    logic            clk;
    logic            reset;
    logic            rd_en;
    logic            clr;
    logic [3:0]      count;
    logic [8*DW-1:0] reg_data;
    logic            rd_take;
    logic [7:0]      rd_sel;
    logic [2:0]      rd_ptr;
    logic [DW-1:0]   dout;
    logic            rd_ack;
    logic            rd_err;

    int tests;
    int fails;
    logic err_exp;

    fifo_read_operation #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .clr      (clr),
        .count    (count),
        .reg_data (reg_data),
        .rd_take  (rd_take),
        .rd_sel   (rd_sel),
        .rd_ptr   (rd_ptr),
        .dout     (dout),
        .rd_ack   (rd_ack),
        .rd_err   (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
`ifdef FIFO_RD_ERR_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        reset    = 1'b1;
        rd_en    = 1'b0;
        clr      = 1'b0;
        count    = 4'd0;
        reg_data = '0;
        for (int i = 0; i < 8; i++) reg_data[i*DW +: DW] = 32'(i + 1);
        reg_data[0 +: DW] = 32'hA5A5_0001;

        // Reset state
        tick();
        tick();
        chk("rst_ptr", 32'(rd_ptr), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_ack", 32'(rd_ack), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);

        // Single read
        reset = 1'b0;
        count = 4'd1;
        rd_en = 1'b1;
        #1;
        chk("single_take", 32'(rd_take), 32'd1);
        chk("single_sel", 32'(rd_sel), 32'h01);
        tick();
        rd_en = 1'b0;
        count = 4'd0;
        chk("single_dout", dout, 32'hA5A5_0001);
        chk("single_ack", 32'(rd_ack), 32'd1);
        chk("single_ptr", 32'(rd_ptr), 32'd1);

        // Asynchronous reset mid-cycle
        reset = 1'b1;
        #1;
        chk("async_ptr", 32'(rd_ptr), 32'd0);
        chk("async_dout", dout, 32'd0);
        chk("async_ack", 32'(rd_ack), 32'd0);
        chk("async_err", 32'(rd_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        reg_data[0 +: DW] = 32'd1;

        // Wrap: eight reads then one underflow request
        count = 4'd8;
        rd_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("wrap_take", 32'(rd_take), 32'd1);
            chk("wrap_sel", 32'(rd_sel), 32'h1 << k);
            chk("wrap_ptr_pre", 32'(rd_ptr), 32'(k));
            tick();
            count = count - 4'd1;
            chk("wrap_dout", dout, 32'(k + 1));
            chk("wrap_ack", 32'(rd_ack), 32'd1);
            chk("wrap_ptr", 32'(rd_ptr), 32'((k + 1) % 8));
        end
        #1;
        chk("wrap9_take", 32'(rd_take), 32'd0);
        chk("wrap9_sel", 32'(rd_sel), 32'd0);
        tick();
        chk("wrap9_err", 32'(rd_err), 32'(err_exp));
        chk("wrap9_ack", 32'(rd_ack), 32'd0);
        chk("wrap9_dout", dout, 32'd8);
        chk("wrap9_ptr", 32'(rd_ptr), 32'd0);

        // Idle cycle clears status
        rd_en = 1'b0;
        tick();
        chk("idle_ack", 32'(rd_ack), 32'd0);
        chk("idle_err", 32'(rd_err), 32'd0);

        // Two reads to move the pointer, then underflow
        count = 4'd2;
        rd_en = 1'b1;
        tick();
        count = 4'd1;
        tick();
        count = 4'd0;
        chk("pre_uf_ptr", 32'(rd_ptr), 32'd2);
        chk("pre_uf_dout", dout, 32'd2);
        #1;
        chk("uf_take", 32'(rd_take), 32'd0);
        chk("uf_sel", 32'(rd_sel), 32'd0);
        tick();
        chk("uf_err", 32'(rd_err), 32'(err_exp));
        chk("uf_ack", 32'(rd_ack), 32'd0);
        chk("uf_ptr", 32'(rd_ptr), 32'd2);
        chk("uf_dout", dout, 32'd2);

        // Move pointer to 5, then flush with a simultaneous read request
        count = 4'd3;
        for (int k = 0; k < 3; k++) begin
            tick();
            count = count - 4'd1;
        end
        chk("pre_clr_ptr", 32'(rd_ptr), 32'd5);
        chk("pre_clr_dout", dout, 32'd5);
        count = 4'd3;
        clr   = 1'b1;
        #1;
        chk("clr_take", 32'(rd_take), 32'd0);
        chk("clr_sel", 32'(rd_sel), 32'd0);
        tick();
        clr   = 1'b0;
        rd_en = 1'b0;
        chk("clr_ptr", 32'(rd_ptr), 32'd0);
        chk("clr_ack", 32'(rd_ack), 32'd0);
        chk("clr_err", 32'(rd_err), 32'd0);
        chk("clr_dout", dout, 32'd5);

        // Illegal count value is treated as non-empty
        count = 4'd12;
        rd_en = 1'b1;
        #1;
        chk("ill_take", 32'(rd_take), 32'd1);
        tick();
        chk("ill_dout", dout, 32'd1);
        chk("ill_ptr", 32'(rd_ptr), 32'd1);

        // Reset during streaming reads
        count = 4'd4;
        tick();
        count = 4'd3;
        chk("strm_ptr", 32'(rd_ptr), 32'd2);
        chk("strm_dout", dout, 32'd2);
        reset = 1'b1;
        #1;
        chk("strm_rst_ptr", 32'(rd_ptr), 32'd0);
        chk("strm_rst_dout", dout, 32'd0);
        chk("strm_rst_ack", 32'(rd_ack), 32'd0);
        chk("strm_rst_take", 32'(rd_take), 32'd1);
        chk("strm_rst_sel", 32'(rd_sel), 32'h01);
        @(negedge clk);
        reset = 1'b0;
        count = 4'd1;
        tick();
        rd_en = 1'b0;
        count = 4'd0;
        chk("post_rst_dout", dout, 32'd1);
        chk("post_rst_ack", 32'(rd_ack), 32'd1);
        chk("post_rst_ptr", 32'(rd_ptr), 32'd1);
        tick();
        chk("post_idle_ack", 32'(rd_ack), 32'd0);
        chk("post_idle_dout", dout, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
